// File: rtl/mc_control_fsm_if.sv
// Memory bus between the multi-cycle sequencer and the shared memory.
// The sequencer drives strobes and address select; memory answers with ready.
interface mc_control_fsm_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V sequencer with memory watchdog and illegal-opcode trap.
// Optional perf counters: define MC_PERF_CNT_EN to build cycle/instret.
module mc_control_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   bus,
  input  logic [6:0]         opcode,
  input  logic               zero,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               memtoreg,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         immsel,
  output logic [3:0]         state,
  output logic [1:0]         fault,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_FAULT  = 4'd9
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] fault_q, fault_d;

  logic mem_rd, mem_wr, ir_wr, pc_wr, reg_wr;
  logic to_hit;

  assign to_hit = (wait_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    fault_d  = fault_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    reg_wr   = 1'b0;
    bus.iord = 1'b0;
    pc_src   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 2'b00;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    immsel   = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        alusrcb = 2'b01;
        if (bus.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        immsel  = 2'b10;
        case (opcode)
          OP_LD, OP_ST: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_BR:        state_d = S_BRANCH;
          default: begin
            state_d = S_FAULT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b10;
        if (opcode == OP_ST) begin
          immsel  = 2'b01;
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        mem_rd   = 1'b1;
        bus.iord = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (to_hit) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_MEMWB: begin
        reg_wr   = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr   = 1'b1;
        bus.iord = 1'b1;
        immsel   = 2'b01;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (to_hit) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_EXEC_R: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        pc_src  = 1'b1;
        pc_wr   = zero;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
        fault_d = 2'b01;
      end
    endcase
  end

  // Strobes are masked during reset so an aborted instruction writes nothing.
  assign bus.mem_read  = mem_rd & ~rst;
  assign bus.mem_write = mem_wr & ~rst;
  assign ir_write      = ir_wr & ~rst;
  assign pc_write      = pc_wr & ~rst;
  assign reg_write     = reg_wr & ~rst;
  assign state         = state_q;
  assign fault         = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
      S_MEMWR: retire = bus.mem_ready;
      default: retire = 1'b0;
    endcase
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (state_q != S_FAULT) cycle_d = cycle_q + 32'd1;
    if (retire) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm (TIMEOUT=4 instance).
// Expected state/control/fault per cycle are queued, then popped and checked.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b0010011;
`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        ir_write, pc_write, pc_src, reg_write, memtoreg;
  logic [1:0]  alusrca, alusrcb, aluop, immsel, fault;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .opcode      (opcode),
    .zero        (zero),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .memtoreg    (memtoreg),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .immsel      (immsel),
    .state       (state),
    .fault       (fault),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [1:0]  flt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {mem_read,mem_write,iord,ir_write,pc_write,pc_src,reg_write,memtoreg,
  //  alusrca,alusrcb,aluop,immsel}
  function automatic logic [15:0] ctl_of(input logic [3:0] st,
      input logic z, input logic rdy, input logic [6:0] op,
      input logic r);
    logic [15:0] c;
    case (st)
      4'd0: c = rdy ? 16'b10011000_00_01_00_00
                    : 16'b10000000_00_01_00_00;
      4'd1: c = 16'b00000000_01_10_00_10;
      4'd2: c = (op == OP_ST) ? 16'b00000000_10_10_00_01
                              : 16'b00000000_10_10_00_00;
      4'd3: c = 16'b10100000_00_00_00_00;
      4'd4: c = 16'b00000011_00_00_00_00;
      4'd5: c = 16'b01100000_00_00_00_01;
      4'd6: c = 16'b00000000_10_00_10_00;
      4'd7: c = 16'b00000010_00_00_00_00;
      4'd8: c = {4'b0000, z, 3'b100, 8'b10_00_01_00};
      default: c = 16'h0000;
    endcase
    if (r) c = c & ~16'hDA00;
    return c;
  endfunction

  task automatic step(input string tag, input logic [3:0] st,
      input logic [1:0] flt, input logic [6:0] op, input logic z,
      input logic rdy, input logic r);
    exp_t e;
    exp_t g;
    opcode        = op;
    zero          = z;
    bus.mem_ready = rdy;
    rst           = r;
    e.st  = st;
    e.ctl = ctl_of(st, z, rdy, op, r);
    e.flt = flt;
    sb.push_back(e);
    #3;
    g = sb.pop_front();
    chk({tag, ".state"}, 32'(state), 32'(g.st));
    chk({tag, ".ctl"}, 32'({bus.mem_read, bus.mem_write, bus.iord,
        ir_write, pc_write, pc_src, reg_write, memtoreg,
        alusrca, alusrcb, aluop, immsel}), 32'(g.ctl));
    chk({tag, ".fault"}, 32'(fault), 32'(g.flt));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [6:0] op,
      input logic z);
    step(tag, 4'd0, 2'b00, op, z, 1'b1, 1'b0);
    step(tag, 4'd1, 2'b00, op, z, 1'b1, 1'b0);
    case (op)
      OP_R: begin
        step(tag, 4'd6, 2'b00, op, z, 1'b1, 1'b0);
        step(tag, 4'd7, 2'b00, op, z, 1'b1, 1'b0);
      end
      OP_LD: begin
        step(tag, 4'd2, 2'b00, op, z, 1'b1, 1'b0);
        step(tag, 4'd3, 2'b00, op, z, 1'b1, 1'b0);
        step(tag, 4'd4, 2'b00, op, z, 1'b1, 1'b0);
      end
      OP_ST: begin
        step(tag, 4'd2, 2'b00, op, z, 1'b1, 1'b0);
        step(tag, 4'd5, 2'b00, op, z, 1'b1, 1'b0);
      end
      default: step(tag, 4'd8, 2'b00, op, z, 1'b1, 1'b0);
    endcase
  endtask

  initial begin
    rst = 1'b1;
    opcode = '0;
    zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cyc", cycle_cnt, 32'd0);
    chk("rst.ret", instret_cnt, 32'd0);
    step("rst", 4'd0, 2'b00, OP_R, 1'b0, 1'b0, 1'b1);

    run("r", OP_R, 1'b0);
    run("ld0", OP_LD, 1'b0);
    run("st0", OP_ST, 1'b0);
    run("br0", OP_BR, 1'b1);
    chk("perf.cyc", cycle_cnt, PERF ? 32'd16 : 32'd0);
    chk("perf.ret", instret_cnt, PERF ? 32'd4 : 32'd0);

    step("ldw", 4'd0, 2'b00, OP_LD, 1'b0, 1'b1, 1'b0);
    step("ldw", 4'd1, 2'b00, OP_LD, 1'b0, 1'b1, 1'b0);
    step("ldw", 4'd2, 2'b00, OP_LD, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("ldw", 4'd3, 2'b00, OP_LD, 1'b0, 1'b0, 1'b0);
    step("ldw", 4'd3, 2'b00, OP_LD, 1'b0, 1'b1, 1'b0);
    step("ldw", 4'd4, 2'b00, OP_LD, 1'b0, 1'b1, 1'b0);

    run("brz", OP_BR, 1'b0);
    run("r2", OP_R, 1'b1);

    step("ill", 4'd0, 2'b00, OP_ILL, 1'b0, 1'b1, 1'b0);
    step("ill", 4'd1, 2'b00, OP_ILL, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step("illf", 4'd9, 2'b01, 7'($urandom), 1'($urandom),
           1'($urandom), 1'b0);
    step("illr", 4'd9, 2'b01, OP_ST, 1'b0, 1'b1, 1'b1);

    step("sto", 4'd0, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    step("sto", 4'd1, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    step("sto", 4'd2, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step("sto", 4'd5, 2'b00, OP_ST, 1'b0, 1'b0, 1'b0);
    step("stof", 4'd9, 2'b10, OP_ST, 1'b0, 1'b1, 1'b0);
    step("stor", 4'd9, 2'b10, OP_ST, 1'b0, 1'b0, 1'b1);

    step("st4", 4'd0, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    step("st4", 4'd1, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    step("st4", 4'd2, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("st4", 4'd5, 2'b00, OP_ST, 1'b0, 1'b0, 1'b0);
    step("st4", 4'd5, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++)
      step("fto", 4'd0, 2'b00, OP_R, 1'b0, 1'b0, 1'b0);
    step("fto", 4'd0, 2'b00, OP_R, 1'b0, 1'b1, 1'b0);
    step("fto", 4'd1, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    step("midr", 4'd2, 2'b00, OP_ST, 1'b0, 1'b1, 1'b0);
    step("midr", 4'd5, 2'b00, OP_ST, 1'b0, 1'b1, 1'b1);
    chk("midr.cyc", cycle_cnt, 32'd0);
    chk("midr.ret", instret_cnt, 32'd0);
    run("r3", OP_R, 1'b0);
    chk("r3.cyc", cycle_cnt, PERF ? 32'd4 : 32'd0);
    chk("r3.ret", instret_cnt, PERF ? 32'd1 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
